// File: rtl/adc_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : adc_scan_pkg
//  Brief   : Shared state encodings and parity helper for the ADC scan link.
//  Revision: 1.0 - initial release
// ============================================================================
package adc_scan_pkg;

    typedef enum logic [2:0] {
        S_MUX  = 3'd0,
        S_SOC  = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_SEND = 3'd4,
        S_TXW  = 3'd5
    } scan_state_e;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_PAR   = 3'd3,
        TX_STOP  = 3'd4
    } tx_state_e;

    localparam int MAX_DATA_W = 16;

    // Payload is zero-extended by the caller; extra zeros do not affect parity.
    function automatic logic parity_bit(input logic [MAX_DATA_W-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module  : uart_frame_tx
//  Brief   : Async serial frame transmitter: start, MSB-first data, parity, stops.
//  Revision: 1.0 - initial release
// ============================================================================
module uart_frame_tx
    import adc_scan_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int BIT_DIV    = 105,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              tx_end,
    output logic              data_out
);

    localparam int              BC_W      = $clog2(BIT_DIV);
    localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BIT_DIV - 1);
    localparam logic [4:0]      DATA_LAST = 5'(DATA_W - 1);
    localparam logic [4:0]      STOP_LAST = 5'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [4:0]        idx_q, idx_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_q, par_d;
    logic              line_q, line_d;
    logic              bit_done;

    assign bit_done = (bc_q == BC_LAST);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        line_d  = line_q;
        tx_end  = 1'b0;
        bc_d    = (state_q == TX_IDLE || bit_done) ? '0 : bc_q + 1'b1;

        case (state_q)
            TX_IDLE: begin
                line_d = 1'b1;
                if (start) begin
                    state_d = TX_START;
                    line_d  = 1'b0;
                    sh_d    = data;
                    par_d   = parity_bit(MAX_DATA_W'(data), PARITY_ODD != 0);
                end
            end
            TX_START: begin
                if (bit_done) begin
                    state_d = TX_DATA;
                    idx_d   = '0;
                    line_d  = sh_q[DATA_W-1];
                    sh_d    = sh_q << 1;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    if (idx_q != DATA_LAST) begin
                        idx_d  = idx_q + 5'd1;
                        line_d = sh_q[DATA_W-1];
                        sh_d   = sh_q << 1;
                    end else if (PARITY_EN != 0) begin
                        state_d = TX_PAR;
                        line_d  = par_q;
                    end else begin
                        state_d = TX_STOP;
                        idx_d   = '0;
                        line_d  = 1'b1;
                    end
                end
            end
            TX_PAR: begin
                if (bit_done) begin
                    state_d = TX_STOP;
                    idx_d   = '0;
                    line_d  = 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    if (idx_q == STOP_LAST) begin
                        tx_end  = 1'b1;
                        state_d = TX_IDLE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= TX_IDLE;
            bc_q    <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            line_q  <= line_d;
        end
    end

    assign busy     = (state_q != TX_IDLE);
    assign data_out = line_q;

endmodule
`default_nettype wire

// File: rtl/adc_scan_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module  : adc_scan_uart_tx
//  Brief   : Round-robin ADC channel scanner shipping each sample as a serial frame.
//  Revision: 1.0 - initial release
// ============================================================================
module adc_scan_uart_tx
    import adc_scan_pkg::*;
#(
    parameter int N_CH       = 8,
    parameter int CH_W       = 4,
    parameter int DATA_W     = 8,
    parameter int BIT_DIV    = 105,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int EOC_TMO    = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              eoc,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dsr,
    output logic              mux_en,
    output logic [CH_W-1:0]   canale,
    output logic              soc,
    output logic              load_dato,
    output logic              data_out,
    output logic              busy,
    output logic              tx_end,
    output logic              error
);

    localparam int              TMO_W   = ($clog2(EOC_TMO + 1) > 8) ? $clog2(EOC_TMO + 1) : 8;
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(EOC_TMO);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(N_CH - 1);

    scan_state_e       state_q, state_d;
    logic [CH_W-1:0]   canale_q, canale_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              mux_en_q, mux_en_d;
    logic              soc_q, soc_d;
    logic              load_q, load_d;
    logic              error_q, error_d;
    logic [TMO_W-1:0]  tmo_inc;
    logic [CH_W-1:0]   canale_nxt;
    logic              frame_start;
    logic              tx_end_w;

    assign tmo_inc    = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
    assign canale_nxt = (canale_q == CH_LAST) ? '0 : canale_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        canale_d    = canale_q;
        tmo_d       = tmo_q;
        sample_d    = sample_q;
        mux_en_d    = mux_en_q;
        soc_d       = soc_q;
        load_d      = 1'b0;
        error_d     = error_q;
        frame_start = 1'b0;

        case (state_q)
            S_MUX: begin
                mux_en_d = 1'b1;
                state_d  = S_SOC;
            end
            S_SOC: begin
                soc_d   = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!eoc) begin
                    load_d   = 1'b1;
                    sample_d = data_in;
                    mux_en_d = 1'b0;
                    state_d  = S_LOAD;
                end else begin
                    tmo_d = tmo_inc;
                    // A stuck converter skips this channel without sending anything.
                    if ((EOC_TMO != 0) && (tmo_inc == TMO_LIM)) begin
                        error_d  = 1'b1;
                        soc_d    = 1'b0;
                        mux_en_d = 1'b0;
                        canale_d = canale_nxt;
                        state_d  = S_MUX;
                    end
                end
            end
            S_LOAD: begin
                soc_d   = 1'b0;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (dsr) begin
                    frame_start = 1'b1;
                    error_d     = 1'b0;
                    state_d     = S_TXW;
                end else begin
                    error_d = 1'b1;
                end
            end
            S_TXW: begin
                if (tx_end_w) begin
                    canale_d = canale_nxt;
                    state_d  = S_MUX;
                end
            end
            default: state_d = S_MUX;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_MUX;
            canale_q <= '0;
            tmo_q    <= '0;
            sample_q <= '0;
            mux_en_q <= 1'b0;
            soc_q    <= 1'b0;
            load_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            canale_q <= canale_d;
            tmo_q    <= tmo_d;
            sample_q <= sample_d;
            mux_en_q <= mux_en_d;
            soc_q    <= soc_d;
            load_q   <= load_d;
            error_q  <= error_d;
        end
    end

    uart_frame_tx #(
        .DATA_W     (DATA_W),
        .BIT_DIV    (BIT_DIV),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD),
        .STOP_BITS  (STOP_BITS)
    ) u_tx (
        .clock    (clock),
        .reset    (reset),
        .start    (frame_start),
        .data     (sample_q),
        .busy     (busy),
        .tx_end   (tx_end_w),
        .data_out (data_out)
    );

    assign mux_en    = mux_en_q;
    assign canale    = canale_q;
    assign soc       = soc_q;
    assign load_dato = load_q;
    assign tx_end    = tx_end_w;
    assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module  : tb_adc_scan_uart_tx
//  Brief   : Directed bench; unit 0 uses default parameters, unit 1 uses odd
//            parity, two stop bits and a 20-clock eoc timeout.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_adc_scan_uart_tx;

    localparam int BIT = 105;

    typedef struct {
        int          u;
        logic [7:0]  data;
        logic [11:0] bits;   // line levels, first-sent bit at position nb-1
        int          nb;
        int          ch;     // expected channel, -1 = not checked
        int          hold;   // clocks with dsr low before the frame may start
        int          abort;  // bit index at which reset hits, -1 = none
    } vec_t;

    logic       clk = 1'b0;
    logic [1:0] rst, eoc, dsr;
    logic [7:0] din [2];
    logic [1:0] mux, soc, ld, dout, bsy, txe, err;
    logic [3:0] can [2];

    int n_chk = 0;
    int n_fail = 0;
    int ld_cnt0 = 0;
    int te_cnt [2] = '{0, 0};
    vec_t tv [13];

    always #5 clk = ~clk;

    adc_scan_uart_tx #(
        .N_CH(8), .CH_W(4), .DATA_W(8), .BIT_DIV(BIT), .PARITY_EN(0),
        .PARITY_ODD(0), .STOP_BITS(1), .EOC_TMO(255)
    ) dut_a (
        .clock(clk), .reset(rst[0]), .eoc(eoc[0]), .data_in(din[0]), .dsr(dsr[0]),
        .mux_en(mux[0]), .canale(can[0]), .soc(soc[0]), .load_dato(ld[0]),
        .data_out(dout[0]), .busy(bsy[0]), .tx_end(txe[0]), .error(err[0])
    );

    adc_scan_uart_tx #(
        .N_CH(8), .CH_W(4), .DATA_W(8), .BIT_DIV(BIT), .PARITY_EN(1),
        .PARITY_ODD(1), .STOP_BITS(2), .EOC_TMO(20)
    ) dut_b (
        .clock(clk), .reset(rst[1]), .eoc(eoc[1]), .data_in(din[1]), .dsr(dsr[1]),
        .mux_en(mux[1]), .canale(can[1]), .soc(soc[1]), .load_dato(ld[1]),
        .data_out(dout[1]), .busy(bsy[1]), .tx_end(txe[1]), .error(err[1])
    );

    always @(posedge clk) begin
        if (ld[0])  ld_cnt0   <= ld_cnt0 + 1;
        if (txe[0]) te_cnt[0] <= te_cnt[0] + 1;
        if (txe[1]) te_cnt[1] <= te_cnt[1] + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic sig_of(input int u, input int s);
        case (s)
            0:       return soc[u];
            1:       return ld[u];
            default: return err[u];
        endcase
    endfunction

    task automatic wait_for(input int u, input int s, input logic v, input string nm);
        int ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sig_of(u, s) === v) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) chk({"timeout ", nm}, 32'd0, 32'd1);
    endtask

    task automatic run_frame(input vec_t v);
        int   u;
        int   t;
        logic bad;
        u = v.u;
        wait_for(u, 0, 1'b0, "soc low");
        wait_for(u, 0, 1'b1, "soc rise");
        chk("mux_en at soc", 32'(mux[u]), 32'd1);
        if (v.ch >= 0) chk("canale", 32'(can[u]), 32'(v.ch));
        if (v.hold > 0) dsr[u] = 1'b0;
        repeat (3) @(negedge clk);
        din[u] = v.data;
        eoc[u] = 1'b0;
        wait_for(u, 1, 1'b1, "load_dato");
        eoc[u] = 1'b1;
        chk("mux_en off at load", 32'(mux[u]), 32'd0);
        @(negedge clk);
        chk("load single cycle", 32'(ld[u]), 32'd0);
        chk("soc cleared", 32'(soc[u]), 32'd0);
        @(negedge clk);
        if (v.hold > 0) begin
            chk("dsr low error", 32'(err[u]), 32'd1);
            bad = (dout[u] !== 1'b1);
            repeat (v.hold) begin
                @(negedge clk);
                if (dout[u] !== 1'b1 || bsy[u] !== 1'b0 || err[u] !== 1'b1) bad = 1'b1;
            end
            chk("idle while dsr low", 32'(bad), 32'd0);
            dsr[u] = 1'b1;
            @(negedge clk);
        end
        chk("start bit", 32'(dout[u]), 32'd0);
        chk("busy at start", 32'(bsy[u]), 32'd1);
        chk("error cleared at start", 32'(err[u]), 32'd0);
        repeat (BIT / 2) @(negedge clk);
        for (int k = 0; k < v.nb; k++) begin
            if (k > 0) repeat (BIT) @(negedge clk);
            if (k == v.abort) begin
                rst[u] = 1'b1;
                @(negedge clk);
                chk("abort line idle", 32'(dout[u]), 32'd1);
                chk("abort busy", 32'(bsy[u]), 32'd0);
                chk("abort canale", 32'(can[u]), 32'd0);
                rst[u] = 1'b0;
                t = te_cnt[u];
                bad = 1'b0;
                repeat (1200) begin
                    @(negedge clk);
                    if (dout[u] !== 1'b1) bad = 1'b1;
                end
                chk("no tx_end after abort", 32'(te_cnt[u]), 32'(t));
                chk("line idle after abort", 32'(bad), 32'd0);
                return;
            end
            chk($sformatf("bit%0d", k), 32'(dout[u]), 32'(v.bits[v.nb-1-k]));
        end
        repeat (BIT / 2 - 1) @(negedge clk);
        chk("tx_end early", 32'(txe[u]), 32'd0);
        @(negedge clk);
        chk("tx_end", 32'(txe[u]), 32'd1);
        chk("last stop high", 32'(dout[u]), 32'd1);
        @(negedge clk);
        chk("tx_end single", 32'(txe[u]), 32'd0);
        chk("busy dropped", 32'(bsy[u]), 32'd0);
        if (v.ch >= 0) chk("canale advance", 32'(can[u]), 32'((v.ch + 1) % 8));
    endtask

    initial begin
        int cnt;
        tv[0]  = '{0, 8'hA5, 12'b0101001011, 10, 0, 0, -1};
        tv[1]  = '{0, 8'h00, 12'b0000000001, 10, 1, 0, -1};
        tv[2]  = '{0, 8'hFF, 12'b0111111111, 10, 2, 0, -1};
        tv[3]  = '{0, 8'h3C, 12'b0001111001, 10, 3, 0, -1};
        tv[4]  = '{0, 8'h81, 12'b0100000011, 10, 4, 0, -1};
        tv[5]  = '{0, 8'h5A, 12'b0010110101, 10, 5, 0, -1};
        tv[6]  = '{0, 8'h01, 12'b0000000011, 10, 6, 0, -1};
        tv[7]  = '{0, 8'hC3, 12'b0110000111, 10, 7, 0, -1};
        tv[8]  = '{0, 8'h3C, 12'b0001111001, 10, 0, 50, -1};
        tv[9]  = '{0, 8'hA5, 12'b0101001011, 10, 1, 0, 5};
        tv[10] = '{1, 8'h03, 12'b000000011111, 12, -1, 0, -1};
        tv[11] = '{1, 8'h07, 12'b000000111011, 12, -1, 0, -1};
        tv[12] = '{1, 8'hF0, 12'b011110000111, 12, -1, 0, -1};

        rst = 2'b11;
        eoc = 2'b11;
        dsr = 2'b11;
        din[0] = 8'h00;
        din[1] = 8'h00;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++)
            chk($sformatf("reset state u%0d", u),
                32'({mux[u], soc[u], ld[u], dout[u], bsy[u], txe[u], err[u], can[u]}),
                32'({7'b0001000, 4'h0}));

        rst[0] = 1'b0;
        for (int i = 0; i < 8; i++) run_frame(tv[i]);
        chk("load_dato pulses", 32'(ld_cnt0), 32'd8);
        chk("tx_end pulses", 32'(te_cnt[0]), 32'd8);
        run_frame(tv[8]);
        run_frame(tv[9]);

        // Unit 1: converter never answers, timeout must fire 20 clocks after soc.
        rst[1] = 1'b0;
        wait_for(1, 0, 1'b1, "soc rise tmo");
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cnt++;
            if (err[1]) break;
        end
        chk("tmo cycles", 32'(cnt), 32'd20);
        chk("tmo soc off", 32'(soc[1]), 32'd0);
        chk("tmo mux off", 32'(mux[1]), 32'd0);
        chk("tmo canale", 32'(can[1]), 32'd1);
        chk("tmo no frame", 32'({bsy[1], dout[1]}), 32'd1);

        for (int i = 10; i < 13; i++) run_frame(tv[i]);
        chk("tx_end pulses u1", 32'(te_cnt[1]), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
